// File: rtl/mnisc_dot_seq.sv
// Signed dot-product sequencer for packed 2-bit activation/weight beats.
// One beat per handshake passes through a pair-sum LUT; a second stage folds it into the accumulator.

module muladd2_lut (
    input  logic [7:0] beat,
    output logic [4:0] sum
);
    // Each pair contributes (a*w + 9)/2, so the total is (a0*w0 + a1*w1 + 18)/2 in 0..18.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_pair
            logic [3:0] q;
            always_comb begin
                q = '0;
                case ({beat[4*gi+3 -: 2], beat[4*gi+1 -: 2]})
                    4'b0000: q = 4'd9;
                    4'b0001: q = 4'd6;
                    4'b0010: q = 4'd3;
                    4'b0011: q = 4'd0;
                    4'b0100: q = 4'd6;
                    4'b0101: q = 4'd5;
                    4'b0110: q = 4'd4;
                    4'b0111: q = 4'd3;
                    4'b1000: q = 4'd3;
                    4'b1001: q = 4'd4;
                    4'b1010: q = 4'd5;
                    4'b1011: q = 4'd6;
                    4'b1100: q = 4'd0;
                    4'b1101: q = 4'd3;
                    4'b1110: q = 4'd6;
                    4'b1111: q = 4'd9;
                    default: q = '0;
                endcase
            end
        end
    endgenerate

    assign sum = {1'b0, g_pair[0].q} + {1'b0, g_pair[1].q};
endmodule

module mnisc_dot_seq #(
    parameter int LEN_W = 8,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             idle,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data,
    output logic [LEN_W-1:0] beats_left
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [LEN_W-1:0] beats_left_reg, beats_left_next;
    logic [4:0]       p1_reg, p1_next;
    logic             p1_v_reg, p1_v_next;
    logic [ACC_W-1:0] acc_reg, acc_next;
    logic [ACC_W-1:0] res_data_reg, res_data_next;
    logic [4:0]       lut_sum;
    logic signed [6:0] contrib;
    logic [ACC_W-1:0] contrib_ext;

    muladd2_lut u_lut (
        .beat (in_data),
        .sum  (lut_sum)
    );

    // LUT output encodes the pair sum as (sum+18)/2; undo that here.
    assign contrib     = $signed({1'b0, p1_reg, 1'b0}) - 7'sd18;
    assign contrib_ext = {{(ACC_W-7){contrib[6]}}, contrib};

    always_comb begin
        state_next      = state_reg;
        beats_left_next = beats_left_reg;
        p1_next         = p1_reg;
        p1_v_next       = 1'b0;
        acc_next        = acc_reg;
        res_data_next   = res_data_reg;

        if (p1_v_reg) begin
            acc_next = acc_reg + contrib_ext;
        end

        case (state_reg)
            IDLE: begin
                if (start) begin
                    acc_next        = '0;
                    beats_left_next = len;
                    state_next      = (len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (in_valid) begin
                    p1_next         = lut_sum;
                    p1_v_next       = 1'b1;
                    beats_left_next = beats_left_reg - LEN_W'(1);
                    if (beats_left_reg == LEN_W'(1)) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_next = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Capture the result together with the final accumulation on entry to DONE.
        if ((state_next == DONE) && (state_reg != DONE)) begin
            res_data_next = acc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            beats_left_reg <= '0;
            p1_reg         <= '0;
            p1_v_reg       <= 1'b0;
            acc_reg        <= '0;
            res_data_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            beats_left_reg <= beats_left_next;
            p1_reg         <= p1_next;
            p1_v_reg       <= p1_v_next;
            acc_reg        <= acc_next;
            res_data_reg   <= res_data_next;
        end
    end

    assign idle       = (state_reg == IDLE);
    assign in_ready   = (state_reg == RUN);
    assign res_valid  = (state_reg == DONE);
    assign res_data   = res_data_reg;
    assign beats_left = beats_left_reg;
endmodule

// File: tb/tb_mnisc_dot_seq.sv
// Bench for mnisc_dot_seq: job-level reference model checked every cycle on two
// instances (ACC_W=16 and ACC_W=12), plus literal expectations for directed jobs.

module tb_mnisc_dot_seq;
    logic        clk = 1'b0;
    logic        rst, start, in_valid, res_ready;
    logic [7:0]  len, in_data;

    logic        idle_a, in_ready_a, res_valid_a;
    logic [15:0] res_data_a;
    logic [7:0]  beats_left_a;
    logic        idle_b, in_ready_b, res_valid_b;
    logic [11:0] res_data_b;
    logic [7:0]  beats_left_b;

    int errors = 0;
    int checks = 0;
    int pcyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) pcyc <= pcyc + 1;

    mnisc_dot_seq #(.LEN_W(8), .ACC_W(16)) dut_a (
        .clk(clk), .rst(rst), .start(start), .len(len), .idle(idle_a),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .res_valid(res_valid_a), .res_ready(res_ready), .res_data(res_data_a),
        .beats_left(beats_left_a)
    );

    mnisc_dot_seq #(.LEN_W(8), .ACC_W(12)) dut_b (
        .clk(clk), .rst(rst), .start(start), .len(len), .idle(idle_b),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .res_valid(res_valid_b), .res_ready(res_ready), .res_data(res_data_b),
        .beats_left(beats_left_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, $signed(act), $signed(exp));
        end
    endtask

    // Code 00,01,10,11 -> -3,-1,+1,+3; beat = a0*w0 + a1*w1.
    function automatic int code_val(input logic [1:0] c);
        return 2 * int'(c) - 3;
    endfunction

    function automatic int beat_val(input logic [7:0] d);
        return code_val(d[1:0]) * code_val(d[3:2]) + code_val(d[5:4]) * code_val(d[7:6]);
    endfunction

    // Reference model: job in progress, result pending, result presented.
    bit     m_on = 1'b0;
    bit     m_busy, m_pend, m_rv;
    int     m_left, m_due;
    longint m_sum, m_res;

    always @(posedge clk) begin
        bit     busy, pend, rv, was_idle;
        int     left, due;
        longint sum, res;
        busy = m_busy; pend = m_pend; rv = m_rv;
        left = m_left; due = m_due; sum = m_sum; res = m_res;
        was_idle = !busy && !pend && !rv;
        if (rst) begin
            busy = 1'b0; pend = 1'b0; rv = 1'b0;
            left = 0; due = 0; sum = 0; res = 0;
            m_on <= 1'b1;
        end else if (m_on) begin
            if (rv && res_ready) rv = 1'b0;
            if (was_idle && start) begin
                sum = 0;
                if (len != 8'd0) begin
                    busy = 1'b1;
                    left = int'(len);
                end else begin
                    pend = 1'b1;
                    due  = pcyc;
                end
            end else if (busy && in_valid) begin
                sum  = sum + beat_val(in_data);
                left = left - 1;
                if (left == 0) begin
                    busy = 1'b0;
                    pend = 1'b1;
                    due  = pcyc + 1;
                end
            end
            if (pend && pcyc == due) begin
                pend = 1'b0;
                rv   = 1'b1;
                res  = sum;
            end
        end
        m_busy <= busy; m_pend <= pend; m_rv <= rv;
        m_left <= left; m_due <= due; m_sum <= sum; m_res <= res;
    end

    always @(negedge clk) begin
        if (m_on) begin
            logic [31:0] ei, el;
            ei = {31'd0, !m_busy && !m_pend && !m_rv};
            el = {24'd0, m_left[7:0]};
            check("idle_a",       {31'd0, idle_a},      ei);
            check("in_ready_a",   {31'd0, in_ready_a},  {31'd0, m_busy});
            check("res_valid_a",  {31'd0, res_valid_a}, {31'd0, m_rv});
            check("beats_left_a", {24'd0, beats_left_a}, el);
            check("res_data_a",   {16'd0, res_data_a},  {16'd0, m_res[15:0]});
            check("idle_b",       {31'd0, idle_b},      ei);
            check("in_ready_b",   {31'd0, in_ready_b},  {31'd0, m_busy});
            check("res_valid_b",  {31'd0, res_valid_b}, {31'd0, m_rv});
            check("beats_left_b", {24'd0, beats_left_b}, el);
            check("res_data_b",   {20'd0, res_data_b},  {20'd0, m_res[11:0]});
        end
    end

    task automatic do_start(input int n);
        start = 1'b1;
        len   = 8'(n);
        @(negedge clk);
        start = 1'b0;
        len   = 8'($urandom);
    endtask

    task automatic send_beat(input logic [7:0] d, input int gap, output int hs);
        int budget;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        budget   = 20;
        while (!in_ready_a && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!in_ready_a) check("beat_accept_timeout", {31'd0, in_ready_a}, 32'd1);
        hs = pcyc;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic wait_result(output int seen);
        int budget;
        budget = 10;
        while (!res_valid_a && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!res_valid_a) check("res_valid_timeout", {31'd0, res_valid_a}, 32'd1);
        seen = pcyc;
    endtask

    task automatic release_res(input int hold, input bit poke);
        logic [15:0] held;
        held      = res_data_a;
        res_ready = 1'b0;
        repeat (hold) begin
            start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            len   = 8'($urandom_range(1, 9));
            @(negedge clk);
        end
        if (hold > 0) begin
            check("hold_res_valid", {31'd0, res_valid_a}, 32'd1);
            check("hold_res_data",  {16'd0, res_data_a}, {16'd0, held});
        end
        start     = poke;
        res_ready = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        res_ready = 1'b0;
        check("idle_after_release", {31'd0, idle_a}, 32'd1);
    endtask

    task automatic run_job(input int n, input logic [7:0] beats[$], input int gaps[$],
                           input int hold, input bit poke,
                           output logic [15:0] r16, output logic [11:0] r12);
        int hs, seen;
        hs = 0;
        do_start(n);
        for (int i = 0; i < n; i++) send_beat(beats[i], gaps[i], hs);
        wait_result(seen);
        if (n > 0) check("result_latency", 32'(seen - hs), 32'd2);
        r16 = res_data_a;
        r12 = res_data_b;
        release_res(hold, poke);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=%0d required=0", pcyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [15:0]  r16;
        logic [11:0]  r12;
        logic [7:0]   sb[5];
        int           se[5];
        logic [7:0]   bq[$];
        int           gq[$];
        int           hs;

        sb = '{8'h00, 8'hFF, 8'hAA, 8'hAC, 8'hCC};
        se = '{18, 18, 2, -8, -18};
        rst = 1'b1; start = 1'b0; len = 8'd0; in_valid = 1'b0; in_data = 8'd0; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_idle",       {31'd0, idle_a},      32'd1);
        check("reset_in_ready",   {31'd0, in_ready_a},  32'd0);
        check("reset_res_valid",  {31'd0, res_valid_a}, 32'd0);
        check("reset_res_data",   {16'd0, res_data_a},  32'd0);
        check("reset_beats_left", {24'd0, beats_left_a}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_job(1, '{sb[i]}, '{0}, 0, 1'b0, r16, r12);
            check("single_pair", 32'($signed(r16)), 32'(se[i]));
        end

        run_job(4, '{8'h00, 8'hFF, 8'hAA, 8'hAC}, '{0, 0, 2, 1}, 0, 1'b0, r16, r12);
        check("len4_sum", 32'($signed(r16)), 32'd30);

        run_job(2, '{8'hAA, 8'hAC}, '{0, 0}, 5, 1'b1, r16, r12);
        check("backpressure_sum", 32'($signed(r16)), -32'sd6);

        do_start(0);
        check("len0_res_valid", {31'd0, res_valid_a}, 32'd1);
        check("len0_res_data",  {16'd0, res_data_a},  32'd0);
        release_res(0, 1'b0);

        bq = {}; gq = {};
        for (int i = 0; i < 255; i++) begin
            bq.push_back(8'h00);
            gq.push_back(0);
        end
        run_job(255, bq, gq, 0, 1'b0, r16, r12);
        check("full_len_acc16", {16'd0, r16}, 32'd4590);
        check("full_len_acc12", {20'd0, r12}, 32'd494);

        do_start(8);
        for (int i = 0; i < 3; i++) send_beat(8'h00, 0, hs);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_idle",       {31'd0, idle_a},      32'd1);
        check("abort_in_ready",   {31'd0, in_ready_a},  32'd0);
        check("abort_res_valid",  {31'd0, res_valid_a}, 32'd0);
        check("abort_beats_left", {24'd0, beats_left_a}, 32'd0);
        run_job(1, '{8'hCC}, '{0}, 0, 1'b0, r16, r12);
        check("after_abort", 32'($signed(r16)), -32'sd18);

        for (int j = 0; j < 30; j++) begin
            int n;
            n = $urandom_range(1, 12);
            bq = {}; gq = {};
            for (int i = 0; i < n; i++) begin
                bq.push_back(8'($urandom));
                gq.push_back($urandom_range(0, 2));
            end
            run_job(n, bq, gq, $urandom_range(0, 3), 1'($urandom_range(0, 1)), r16, r12);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
